// File: rtl/quadrature_step_decoder.sv
// x4 quadrature decoder: synchronizes raw A/B, emits a 1-cycle step pulse plus direction,
// and counts illegal double-edge transitions. Define QDEC_GLITCH_FILTER_EN for the stability filter.
module quadrature_step_decoder #(
  parameter int FilterDepth = 4,
  parameter int ErrCntWidth = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   quad_a,
  input  logic                   quad_b,
  output logic                   step,
  output logic                   up_down,
  output logic                   err,
  output logic [ErrCntWidth-1:0] err_cnt
);

`ifdef QDEC_GLITCH_FILTER_EN
  localparam bit FiltEn = 1'b1;
`else
  localparam bit FiltEn = 1'b0;
`endif
  localparam int Settle = 2 + (FiltEn ? FilterDepth : 0);
  localparam int SetW   = $clog2(Settle + 1);

  typedef enum logic {ST_INIT, ST_TRACK} state_e;

  logic [1:0] meta_q, sync_q;  // bit 1 = channel A, bit 0 = channel B
  logic [1:0] phase;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      // NOTE: nothing may sit between the two synchronizer flops; the first may go metastable.
      meta_q <= {quad_a, quad_b};
      sync_q <= meta_q;
    end
  end

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int FcW = (FilterDepth > 1) ? $clog2(FilterDepth) : 1;

  logic [1:0]     filt_q;
  logic [FcW-1:0] fcnt_q [2];

  // A channel is accepted only after it has disagreed with the filtered value for FilterDepth cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q    <= '0;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FcW'(FilterDepth - 1)) begin
          filt_q[i] <= sync_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign phase = filt_q;
`else
  assign phase = sync_q;
`endif

  state_e                 state_q;
  logic [SetW-1:0]        settle_q;
  logic [1:0]             prev_q;
  logic                   step_q, err_q, up_down_q;
  logic [ErrCntWidth-1:0] err_cnt_q;

  logic [1:0] delta;
  logic       dir_up;

  assign delta  = phase ^ prev_q;
  // Along 00->10->11->01->00 the new A bit always differs from the old B bit.
  assign dir_up = phase[1] ^ prev_q[0];

  // INIT runs until the sync/filter pipeline holds real input, then captures it as prev.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      settle_q  <= '0;
      prev_q    <= '0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      up_down_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      step_q <= 1'b0;
      err_q  <= 1'b0;
      prev_q <= phase;
      case (state_q)
        ST_INIT: begin
          if (settle_q == SetW'(Settle)) state_q <= ST_TRACK;
          else                           settle_q <= settle_q + 1'b1;
        end
        ST_TRACK: begin
          if (enable) begin
            if (delta == 2'b11) begin
              err_q <= 1'b1;
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            end else if (delta != 2'b00) begin
              step_q    <= 1'b1;
              up_down_q <= dir_up;
            end
          end
        end
      endcase
    end
  end

  assign step    = step_q;
  assign err     = err_q;
  assign up_down = up_down_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Scoreboard bench for quadrature_step_decoder: a phase-index model predicts each pulse,
// a negedge monitor pops and compares whenever step or err is presented.
module tb_quadrature_step_decoder;

  localparam int FilterDepth = 4;
  localparam int ErrCntWidth = 8;
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int Lat    = 3 + FilterDepth;
  localparam int Settle = 2 + FilterDepth;
`else
  localparam int Lat    = 3;
  localparam int Settle = 2;
`endif
  localparam int CntMax = (1 << ErrCntWidth) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   enable = 1'b0;
  logic                   quad_a = 1'b0;
  logic                   quad_b = 1'b0;
  logic                   step, up_down, err;
  logic [ErrCntWidth-1:0] err_cnt;

  quadrature_step_decoder #(
    .FilterDepth(FilterDepth),
    .ErrCntWidth(ErrCntWidth)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .quad_a (quad_a),
    .quad_b (quad_b),
    .step   (step),
    .up_down(up_down),
    .err    (err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    bit dir;
    int cnt;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  n_pushed = 0;
  int  n_seen   = 0;

  // Reference model: position on the 4-entry Gray cycle, last direction, error count.
  logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int idx   = 2;
  bit m_dir = 1'b0;
  int m_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // delta: 1 = one step up, 3 = one step down, 2 = illegal jump of both channels.
  task automatic move(input int delta, input int gap);
    ev_t e;
    @(posedge clk);
    #2;
    idx = (idx + delta) % 4;
    {quad_a, quad_b} = gray[idx];
    if (enable) begin
      if (delta == 2) begin
        if (m_cnt < CntMax) m_cnt++;
        e = '{is_err: 1'b1, dir: m_dir, cnt: m_cnt, cyc: cyc};
      end else begin
        m_dir = (delta == 1);
        e = '{is_err: 1'b0, dir: m_dir, cnt: m_cnt, cyc: cyc};
      end
      exp_q.push_back(e);
      n_pushed++;
    end
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic set_en(input bit v);
    @(posedge clk);
    #2;
    enable = v;
  endtask

  always @(negedge clk) begin
    if (rst_n && (step || err)) begin : pop_blk
      ev_t e;
      n_seen++;
      check("step_err_exclusive", longint'(step && err), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", longint'({step, err}), 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_is_err", longint'(err), longint'(e.is_err));
        check("pulse_latency", cyc - e.cyc, Lat);
        check("pulse_up_down", longint'(up_down), longint'(e.dir));
        check("pulse_err_cnt", longint'(err_cnt), e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int base;

    // Reset held with A=B=1, then released: INIT must swallow the pipeline fill.
    quad_a = 1'b1;
    quad_b = 1'b1;
    enable = 1'b1;
    #12;
    check("rst_step", longint'(step), 0);
    check("rst_err", longint'(err), 0);
    check("rst_up_down", longint'(up_down), 0);
    check("rst_err_cnt", longint'(err_cnt), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check("t1_no_pulse", n_seen, 0);
    check("t1_err_cnt", longint'(err_cnt), 0);
    check("t1_up_down", longint'(up_down), 0);

    // Walk to 00, four full up cycles, then eight reverse edges.
    move(1, 10);
    move(1, 10);
    base = n_seen;
    for (int i = 0; i < 16; i++) move(1, 10);
    check("t2_up_steps", n_seen - base, 16);
    check("t2_up_down_up", longint'(up_down), 1);
    base = n_seen;
    for (int i = 0; i < 8; i++) move(3, 10);
    check("t2_down_steps", n_seen - base, 8);
    check("t2_up_down_down", longint'(up_down), 0);

    // Illegal jumps leave direction alone and saturate the counter.
    for (int i = 0; i < 4; i++) move(1, 10);
    base = n_seen;
    move(2, Lat + 3);
    move(2, Lat + 3);
    check("t3_err_pulses", n_seen - base, 2);
    check("t3_err_cnt_2", longint'(err_cnt), 2);
    check("t3_up_down_kept", longint'(up_down), 1);
    for (int i = 0; i < 298; i++) move(2, Lat + 2);
    repeat (Lat + 2) @(posedge clk);
    check("t3_err_cnt_sat", longint'(err_cnt), CntMax);

    // Disabled edges are tracked silently; re-enable gives no spurious pulse.
    set_en(1'b0);
    base = n_seen;
    for (int i = 0; i < 4; i++) move(1, 10);
    set_en(1'b1);
    repeat (20) @(posedge clk);
    check("t4_silent", n_seen - base, 0);
    move(1, 10);
    check("t4_one_step", n_seen - base, 1);

`ifdef QDEC_GLITCH_FILTER_EN
    // A 3-cycle glitch on A must be rejected; a stable change is accepted.
    base = n_seen;
    @(posedge clk);
    #2;
    quad_a = ~quad_a;
    repeat (3) @(posedge clk);
    #2;
    quad_a = ~quad_a;
    repeat (20) @(posedge clk);
    check("t5_glitch_rejected", n_seen - base, 0);
    move(1, 20);
    check("t5_stable_step", n_seen - base, 1);
`endif

    // Async reset mid-sequence: pending edge is discarded and INIT repeats.
    move(1, 10);
    check("t6_up_down_before", longint'(up_down), 1);
    move(1, 2);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    n_pushed = n_seen;
    m_dir = 1'b0;
    m_cnt = 0;
    #1;
    check("t6_async_step", longint'(step), 0);
    check("t6_async_err", longint'(err), 0);
    check("t6_async_up_down", longint'(up_down), 0);
    check("t6_async_err_cnt", longint'(err_cnt), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    base = n_seen;
    repeat (Settle + 15) @(posedge clk);
    check("t6_no_pulse_in_init", n_seen - base, 0);
    move(1, 10);
    check("t6_first_step", n_seen - base, 1);

    // Randomized walk with occasional enable toggles.
    for (int i = 0; i < 60; i++) begin
      int r;
      int d;
      r = int'($urandom_range(0, 9));
      d = (r < 5) ? 1 : ((r < 9) ? 3 : 2);
      if ($urandom_range(0, 7) == 0) set_en(~enable);
      move(d, int'($urandom_range(Lat + 2, Lat + 8)));
    end

    repeat (Lat + 5) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_pulse_total", n_seen, n_pushed);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
